// File: rtl/bk_sd_ctrl.sv
// Backup-RAM sector sequencer: on a load/save request, walks every sector of each
// valid virtual disk and streams the HPS sector buffer to/from backup memory.
module bk_sd_ctrl #(
    parameter int VD0_SECTORS = 64,
    parameter int VD1_SECTORS = 256
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  img_mounted,
    input  logic [63:0] img_size,
    input  logic        bk_load,
    input  logic        bk_save,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        bk_saving,
    input  logic [1:0]  core_dirty,
    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic [1:0]  sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    output logic        mem_vd,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_REQ  = 3'd2,
        S_XFER = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    localparam logic [63:0] VD0_BYTES = 64'(VD0_SECTORS) * 64'd512;
    localparam logic [63:0] VD1_BYTES = 64'(VD1_SECTORS) * 64'd512;
    localparam logic [7:0]  VD0_LAST  = 8'(VD0_SECTORS - 1);
    localparam logic [7:0]  VD1_LAST  = 8'(VD1_SECTORS - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_valid;
    logic [1:0]  r_dirty;
    logic [1:0]  r_done;
    logic        r_op_save;
    logic        r_loading;
    logic        r_saving;
    logic        r_vd;
    logic [7:0]  r_sector;
    logic        r_load_d;
    logic        r_save_d;
    logic [1:0]  r_sd_rd;
    logic [1:0]  r_sd_wr;

    logic        w_ena;
    logic        w_load_edge;
    logic        w_save_edge;
    logic [1:0]  w_vd_oh;
    logic        w_ack;
    logic        w_on_vd;
    logic        w_abort;
    logic        w_last;
    logic        w_xfer;
    logic [1:0]  w_cand;
    logic        w_start_load;
    logic        w_start_save;
    logic        w_pick_vld;
    logic        w_pick;
    logic        w_vd_done;
    logic        w_sel_empty;
    logic        w_save_done;
    logic [1:0]  w_dirty_clr;

    assign w_ena       = |r_valid;
    assign w_load_edge = bk_load & ~r_load_d;
    assign w_save_edge = bk_save & ~r_save_d;
    assign w_vd_oh     = r_vd ? 2'b10 : 2'b01;
    assign w_ack       = |(sd_ack & w_vd_oh);
    assign w_on_vd     = (r_state == S_REQ) || (r_state == S_XFER) || (r_state == S_NEXT);
    // A remount of the disk being walked abandons it; the new valid flag takes over.
    assign w_abort     = w_on_vd & (|(img_mounted & w_vd_oh));
    assign w_last      = (r_sector == (r_vd ? VD1_LAST : VD0_LAST));
    assign w_cand      = r_valid & ~r_done & (r_op_save ? r_dirty : 2'b11);
    assign w_dirty_clr = (w_save_done ? w_vd_oh : 2'b00)
                       | ((w_pick_vld & ~r_op_save) ? (w_pick ? 2'b10 : 2'b01) : 2'b00);

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nx   = r_state;
        w_start_load = 1'b0;
        w_start_save = 1'b0;
        w_pick_vld   = 1'b0;
        w_pick       = 1'b0;
        w_vd_done    = 1'b0;
        w_sel_empty  = 1'b0;
        w_save_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ena && w_load_edge) begin
                    w_start_load = 1'b1;
                    w_state_nx   = S_SEL;
                end else if (w_ena && w_save_edge) begin
                    w_start_save = 1'b1;
                    w_state_nx   = S_SEL;
                end else begin
                    w_state_nx   = S_IDLE;
                end
            end
            S_SEL: begin
                if (w_cand[0]) begin
                    w_pick_vld = 1'b1;
                    w_pick     = 1'b0;
                    w_state_nx = S_REQ;
                end else if (w_cand[1]) begin
                    w_pick_vld = 1'b1;
                    w_pick     = 1'b1;
                    w_state_nx = S_REQ;
                end else begin
                    w_sel_empty = 1'b1;
                    w_state_nx  = S_IDLE;
                end
            end
            S_REQ: begin
                if (w_abort) begin
                    w_vd_done  = 1'b1;
                    w_state_nx = S_SEL;
                end else if (w_ack) begin
                    w_state_nx = S_XFER;
                end else begin
                    w_state_nx = S_REQ;
                end
            end
            S_XFER: begin
                if (w_abort) begin
                    w_vd_done  = 1'b1;
                    w_state_nx = S_SEL;
                end else if (!w_ack) begin
                    w_state_nx = S_NEXT;
                end else begin
                    w_state_nx = S_XFER;
                end
            end
            S_NEXT: begin
                if (w_abort) begin
                    w_vd_done  = 1'b1;
                    w_state_nx = S_SEL;
                end else if (w_last) begin
                    w_vd_done   = 1'b1;
                    w_save_done = r_op_save;
                    w_state_nx  = S_SEL;
                end else begin
                    w_state_nx  = S_REQ;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Request edge detection, operation latch and busy flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_load_d  <= 1'b0;
            r_save_d  <= 1'b0;
            r_op_save <= 1'b0;
            r_loading <= 1'b0;
            r_saving  <= 1'b0;
        end else begin
            r_load_d <= bk_load;
            r_save_d <= bk_save;
            if (w_start_load) begin
                r_op_save <= 1'b0;
                r_loading <= 1'b1;
            end else if (w_start_save) begin
                r_op_save <= 1'b1;
                r_saving  <= 1'b1;
            end else if (w_sel_empty) begin
                r_loading <= 1'b0;
                r_saving  <= 1'b0;
            end
        end
    end

    // Disk/sector walk position and per-operation done flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vd     <= 1'b0;
            r_sector <= 8'd0;
            r_done   <= 2'b00;
        end else begin
            if (w_pick_vld) begin
                r_vd     <= w_pick;
                r_sector <= 8'd0;
            end else if ((r_state == S_NEXT) && (w_state_nx == S_REQ)) begin
                r_sector <= r_sector + 8'd1;
            end
            if (w_sel_empty) begin
                r_done <= 2'b00;
            end else if (w_vd_done) begin
                r_done <= r_done | w_vd_oh;
            end
        end
    end

    // Image validity from mount size; dirty tracking where a new core write beats a clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 2'b00;
            r_dirty <= 2'b00;
        end else begin
            if (img_mounted[0]) begin
                r_valid[0] <= (img_size >= VD0_BYTES);
            end
            if (img_mounted[1]) begin
                r_valid[1] <= (img_size >= VD1_BYTES);
            end
            r_dirty <= core_dirty | (r_dirty & ~w_dirty_clr);
        end
    end

    // Sector request lines: held until the first cycle the HPS acknowledges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sd_rd <= 2'b00;
            r_sd_wr <= 2'b00;
        end else if ((r_state == S_REQ) && (w_state_nx == S_REQ)) begin
            r_sd_rd <= r_op_save ? 2'b00 : w_vd_oh;
            r_sd_wr <= r_op_save ? w_vd_oh : 2'b00;
        end else begin
            r_sd_rd <= 2'b00;
            r_sd_wr <= 2'b00;
        end
    end

    assign w_xfer      = (r_state == S_XFER) & ~w_abort;
    assign bk_ena      = w_ena;
    assign bk_loading  = r_loading;
    assign bk_saving   = r_saving;
    assign sd_lba      = {24'd0, r_sector};
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign mem_vd      = w_xfer & r_vd;
    assign mem_addr    = w_xfer ? {r_sector, sd_buff_addr} : 16'd0;
    assign mem_we      = w_xfer & ~r_op_save & sd_buff_wr;
    assign mem_wdata   = (w_xfer & ~r_op_save) ? sd_buff_dout : 16'd0;
    assign sd_buff_din = (w_xfer & r_op_save) ? mem_rdata : 16'd0;

endmodule

// File: tb/tb_bk_sd_ctrl.sv
// Directed bench for bk_sd_ctrl: HPS and backup-memory models driven from one sequence.
module tb_bk_sd_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [1:0]  img_mounted;
    logic [63:0] img_size;
    logic        bk_load;
    logic        bk_save;
    logic        bk_ena;
    logic        bk_loading;
    logic        bk_saving;
    logic [1:0]  core_dirty;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic        mem_vd;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int we0;

    bk_sd_ctrl #(.VD0_SECTORS(64), .VD1_SECTORS(256)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .bk_load      (bk_load),
        .bk_save      (bk_save),
        .bk_ena       (bk_ena),
        .bk_loading   (bk_loading),
        .bk_saving    (bk_saving),
        .core_dirty   (core_dirty),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_vd       (mem_vd),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] pat(input logic vd, input logic [15:0] a);
        return a ^ (vd ? 16'hA5C3 : 16'h3C5A);
    endfunction

    // Backup memory model: synchronous read of a fixed pattern, one cycle latency.
    always @(posedge clk_sys) mem_rdata <= pat(mem_vd, mem_addr);

    // Count every memory write strobe seen at a clock edge.
    always @(posedge clk_sys) if (mem_we === 1'b1) n_we <= n_we + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic mount(input logic vd, input logic [63:0] size);
        img_size    = size;
        img_mounted = vd ? 2'b10 : 2'b01;
        tick();
        img_mounted = 2'b00;
    endtask

    task automatic hps_req(input logic vd, input logic save, input int lba);
        int k;
        logic [1:0] oh;
        oh = vd ? 2'b10 : 2'b01;
        k = 0;
        while (((save ? sd_wr : sd_rd) !== oh) && (k < 40)) begin
            tick();
            k++;
        end
        check("req_seen", 64'(k < 40), 64'(1'b1));
        check("req_lines", 64'({sd_rd, sd_wr}), 64'(save ? {2'b00, oh} : {oh, 2'b00}));
        check("req_lba", 64'(sd_lba), 64'(lba));
        tick();
        check("req_hold", 64'({sd_rd, sd_wr}), 64'(save ? {2'b00, oh} : {oh, 2'b00}));
        sd_ack = oh;
        tick();
        check("req_drop", 64'({sd_rd, sd_wr}), 64'(4'b0000));
    endtask

    task automatic hps_stream(input logic vd, input logic save, input int lba, input int nwords);
        logic [15:0] a;
        for (int w = 0; w < nwords; w++) begin
            a = 16'(lba * 256 + w);
            sd_buff_addr = 8'(w);
            if (!save) begin
                sd_buff_dout = a;
                sd_buff_wr   = 1'b1;
                #1;
                check("load_word", 64'({mem_we, mem_vd, mem_addr, mem_wdata}), 64'({1'b1, vd, a, a}));
                tick();
            end else begin
                #1;
                check("save_addr", 64'({mem_we, mem_vd, mem_addr}), 64'({1'b0, vd, a}));
                tick();
                check("save_din", 64'(sd_buff_din), 64'(pat(vd, a)));
                tick();
            end
        end
        sd_buff_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; img_mounted = 2'b00; img_size = 64'd0;
        bk_load = 1'b0; bk_save = 1'b0; core_dirty = 2'b00; sd_ack = 2'b00;
        sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
        tick(); tick();
        #1;
        check("rst_flags", 64'({bk_ena, bk_loading, bk_saving, sd_rd, sd_wr}), 64'(7'd0));
        check("rst_lba", 64'(sd_lba), 64'd0);
        check("rst_mem", 64'({mem_we, mem_vd, mem_addr, mem_wdata, sd_buff_din}), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Undersized images leave the disk invalid; requests are dropped.
        mount(1'b0, 64'd1000);
        check("small_ena", 64'(bk_ena), 64'd0);
        mount(1'b0, 64'd32767);
        check("edge_ena", 64'(bk_ena), 64'd0);
        bk_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("small_idle", 64'({bk_loading, sd_rd}), 64'd0);
        end
        bk_load = 1'b0;
        tick();

        // Full load of vd0, word i = i.
        mount(1'b0, 64'd32768);
        check("vd0_ena", 64'(bk_ena), 64'd1);
        we0 = n_we;
        bk_load = 1'b1;
        tick();
        check("load_busy", 64'({bk_loading, bk_saving, sd_rd}), 64'({1'b1, 1'b0, 2'b00}));
        bk_load = 1'b0;
        tick();
        check("rd_early", 64'(sd_rd), 64'd0);
        tick();
        check("rd_latency", 64'(sd_rd), 64'(2'b01));
        for (int s = 0; s < 64; s++) begin
            hps_req(1'b0, 1'b0, s);
            hps_stream(1'b0, 1'b0, s, 256);
            sd_ack = 2'b00;
        end
        tick(); tick();
        check("load_tail_busy", 64'(bk_loading), 64'd1);
        tick();
        check("load_end", 64'({bk_loading, sd_rd}), 64'd0);
        check("load_we_count", 64'(n_we - we0), 64'd16384);
        check("load_ena", 64'(bk_ena), 64'd1);

        // Save: both mounted, only vd1 dirty.
        mount(1'b1, 64'd131072);
        core_dirty = 2'b10;
        tick();
        core_dirty = 2'b00;
        we0 = n_we;
        bk_save = 1'b1;
        tick();
        check("save_busy", 64'({bk_loading, bk_saving}), 64'(2'b01));
        bk_save = 1'b0;
        for (int s = 0; s < 256; s++) begin
            hps_req(1'b1, 1'b1, s);
            hps_stream(1'b1, 1'b1, s, 2);
            sd_ack = 2'b00;
        end
        tick(); tick();
        check("save_tail_busy", 64'(bk_saving), 64'd1);
        tick();
        check("save_end", 64'(bk_saving), 64'd0);
        check("save_no_we", 64'(n_we - we0), 64'd0);

        // Second save: nothing dirty, no sector writes.
        bk_save = 1'b1;
        tick();
        check("save2_busy", 64'(bk_saving), 64'd1);
        bk_save = 1'b0;
        tick();
        check("save2_end", 64'(bk_saving), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("save2_no_wr", 64'({sd_rd, sd_wr}), 64'd0);
            tick();
        end

        // Simultaneous edges pick load; a save edge while busy is ignored.
        bk_load = 1'b1;
        bk_save = 1'b1;
        tick();
        check("both_load", 64'({bk_loading, bk_saving}), 64'(2'b10));
        bk_save = 1'b0;
        tick();
        bk_save = 1'b1;
        tick();
        check("busy_save_drop", 64'({bk_loading, bk_saving}), 64'(2'b10));
        bk_save = 1'b0;
        bk_load = 1'b0;
        for (int s = 0; s < 64; s++) begin
            hps_req(1'b0, 1'b0, s);
            hps_stream(1'b0, 1'b0, s, 1);
            sd_ack = 2'b00;
        end
        for (int s = 0; s < 10; s++) begin
            hps_req(1'b1, 1'b0, s);
            hps_stream(1'b1, 1'b0, s, 1);
            sd_ack = 2'b00;
        end

        // Remount vd1 mid-sector 10: abort, then no more work.
        hps_req(1'b1, 1'b0, 10);
        hps_stream(1'b1, 1'b0, 10, 3);
        sd_buff_addr = 8'd3;
        sd_buff_dout = 16'hBEEF;
        sd_buff_wr = 1'b1;
        img_size = 64'd131072;
        img_mounted = 2'b10;
        tick();
        img_mounted = 2'b00;
        we0 = n_we;
        check("abort_sel", 64'({bk_loading, sd_rd}), 64'({1'b1, 2'b00}));
        tick();
        check("abort_idle", 64'({bk_loading, sd_rd}), 64'd0);
        tick(); tick(); tick();
        check("abort_no_we", 64'(n_we - we0), 64'd0);
        sd_ack = 2'b00;
        sd_buff_wr = 1'b0;
        check("abort_ena", 64'(bk_ena), 64'd1);
        tick();

        // Asynchronous reset in the middle of a sector transfer.
        bk_load = 1'b1;
        tick();
        bk_load = 1'b0;
        hps_req(1'b0, 1'b0, 0);
        sd_buff_addr = 8'd5;
        sd_buff_dout = 16'h1234;
        sd_buff_wr = 1'b1;
        #1;
        check("pre_rst_we", 64'({mem_we, mem_addr}), 64'({1'b1, 16'h0005}));
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_flags", 64'({bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, mem_we, mem_vd}), 64'd0);
        check("mid_rst_data", 64'({sd_lba[15:0], mem_addr, mem_wdata, sd_buff_din}), 64'd0);
        tick();
        reset_n = 1'b1;
        sd_ack = 2'b00;
        sd_buff_wr = 1'b0;
        tick();
        check("post_rst_ena", 64'(bk_ena), 64'd0);
        bk_load = 1'b1;
        tick();
        check("post_rst_load", 64'({bk_loading, sd_rd}), 64'd0);
        bk_load = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bk_sd_ctrl.md
# bk_sd_ctrl

Backup-RAM sector sequencer between the HPS virtual-disk interface (`sd_*`, two images: vd0 internal backup SRAM, vd1 external FX-BMP) and the core's backup memory port. On a `bk_load`/`bk_save` request it walks every sector of each valid mounted image in turn. It issues one-hot `sd_rd`/`sd_wr` per sector and streams the 256-word sector buffer to or from memory. Sits in `pcfx_top` beside the SDRAM/backup-RAM interfaces; it is the sole owner of `sd_lba`, `sd_rd`, `sd_wr` and `sd_buff_din`.

## Interface
- `VD0_SECTORS`, 64: sectors in vd0 (32 KiB).
- `VD1_SECTORS`, 256: sectors in vd1 (128 KiB); both must be ≤256.
- `clk_sys  in  1  core clock`
- `reset_n  in  1  reset, asynchronous, active-low`
- `img_mounted  in  2  one-cycle mount pulse per vd`
- `img_size  in  64  image size in bytes, valid with img_mounted`
- `bk_load, bk_save  in  1  request levels, rising-edge detected`
- `bk_ena  out  1  OR of vd valid flags`
- `bk_loading, bk_saving  out  1  busy flags`
- `core_dirty  in  2  pulse: core wrote backup memory of vd[i]`
- `sd_lba  out  32  sector index within image`
- `sd_rd, sd_wr  out  2  one-hot sector request`
- `sd_ack  in  2  HPS transfer active per vd`
- `sd_buff_addr  in  8  word index in sector`
- `sd_buff_dout  in  16  read data from HPS`
- `sd_buff_wr  in  1  sd_buff_dout strobe`
- `sd_buff_din  out  16  write data to HPS`
- `mem_vd  out  1  target memory select`
- `mem_addr  out  16  word address = {sector[7:0], sd_buff_addr}`
- `mem_we  out  1  write strobe`
- `mem_wdata  out  16  = sd_buff_dout`
- `mem_rdata  in  16  read data, 1-cycle registered latency from mem_addr`

## Operation
- Reset values: all outputs 0; valid[1:0]=0, dirty[1:0]=0, state IDLE, edge-detect registers 0.
- valid[i] updates on img_mounted[i]: set iff img_size ≥ VDi_SECTORS*512; an undersized image clears it.
- dirty[i] is set by core_dirty[i]. It is cleared when a save of vd i completes or a load of vd i starts. Set wins if it coincides with clear.
- Request latch in IDLE only: rising edge of bk_load → op=LOAD, bk_loading=1; else rising edge of bk_save → op=SAVE, bk_saving=1. Load wins if both edges occur together. Edges arriving while busy are dropped. A request with bk_ena=0 is dropped.
- State machine:
  - IDLE: wait for a latched request → SEL.
  - SEL: pick the lowest vd that is valid, not yet done this op, and (for SAVE) dirty. None left → IDLE; busy flag clears and done flags clear. Otherwise set sector=0 → REQ.
  - REQ: drive sd_lba=sector and sd_rd[vd] (LOAD) or sd_wr[vd] (SAVE). On sd_ack[vd]=1 drop the request → XFER.
  - XFER: while sd_ack[vd]=1, stream data. On sd_ack[vd] falling → NEXT.
  - NEXT: if sector==VDx_SECTORS-1, mark vd done (SAVE: clear dirty) → SEL; else sector+1 → REQ.
- Data path, LOAD in XFER: mem_we = sd_buff_wr, combinational; mem_addr = {sector, sd_buff_addr}; mem_vd=vd.
- Data path, SAVE in XFER: mem_addr follows sd_buff_addr; sd_buff_din = mem_rdata. HPS holds sd_buff_addr ≥2 cycles per word.
- mem_we is never asserted outside LOAD/XFER.
- img_mounted[vd] during an active transfer of that vd aborts the vd: drop sd_rd/sd_wr, mark it done, go to SEL on the next cycle. The new valid value applies from then on.
- Mid-op reset_n assertion returns everything to reset values immediately, including valid and dirty.
- sd_lba[31:8]=0 always.

## Timing
- bk_load edge at cycle N: bk_loading=1 at N+1, SEL at N+1, sd_rd visible at N+3.
- sd_rd/sd_wr stay asserted until the first cycle sd_ack[vd] is sampled high, then deassert on the next edge.
- Per-sector overhead excluding the HPS: 2 cycles (NEXT + REQ).
- bk_loading/bk_saving fall one cycle after SEL finds no work.
- Memory read latency is 1 cycle; sd_buff_din is valid from the second cycle of each sd_buff_addr value.

## Test plan
- Mount vd0 with img_size=32768, pulse bk_load; HPS model feeds word i = i. Expect 64 sd_rd[0] requests with lba 0..63 and 16384 mem_we with mem_addr = word index. bk_loading falls after lba 63; bk_ena=1.
- Mount vd0 with img_size=1000 → valid0=0, bk_ena=0. bk_load produces no sd_rd and bk_loading stays 0.
- Mount both vds and pulse core_dirty[1] only, then bk_save. Expect only vd1 sd_wr lba 0..255, with sd_buff_din equal to memory contents. dirty1=0 after the save; a second bk_save issues no sd_wr.
- Assert bk_load and bk_save rising edges on the same cycle → LOAD only. A further bk_save edge while bk_loading=1 is ignored.
- Pulse img_mounted[1] during vd1 sector 10 of a load → transfer aborts, next SEL returns to IDLE, and no mem_we follows the abort.
- Drop reset_n mid-XFER → all outputs 0 on the same edge; valid=0; bk_ena=0.
